// File: rtl/ex_div_pkg.sv
// ============================================================================
// ex_div_pkg : shared state encodings and constants for the ex_div divider
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic RST_ENABLE           = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int          DIV_DATA_W   = 32;
  localparam int          DOUBLE_REG_W = 2 * DIV_DATA_W;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/ex_div_step.sv
// ============================================================================
// ex_div_step : one restoring-division step (shift in a bit, trial subtract)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ex_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_q
);

  logic [DATA_W:0] w_shift;
  logic            w_ge;

  // Remainder stays below the divisor, so either branch fits back into DATA_W.
  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = w_ge ? DATA_W'(w_shift - {1'b0, i_divisor}) : w_shift[DATA_W-1:0];
  assign o_q     = w_ge;

endmodule

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// ex_div : multi-cycle restoring divider (DIV/DIVU), result = {HI rem, LO quot}
// Optional macro EX_DIV_RADIX4_EN: two quotient bits per cycle.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

`ifdef EX_DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - STEPS);

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dvd;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quot;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_res;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic [DATA_W-1:0] w_rem1;
  logic              w_q1;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quot_nxt;
  logic [DATA_W-1:0] w_dvd_nxt;
  logic [DATA_W-1:0] w_quot_fin;
  logic [DATA_W-1:0] w_rem_fin;
  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;

  ex_div_step #(.DATA_W(DATA_W)) u_step0 (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[DATA_W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem1),
    .o_q       (w_q1)
  );

`ifdef EX_DIV_RADIX4_EN
  logic [DATA_W-1:0] w_rem2;
  logic              w_q2;

  ex_div_step #(.DATA_W(DATA_W)) u_step1 (
    .i_rem     (w_rem1),
    .i_bit     (r_dvd[DATA_W-2]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem2),
    .o_q       (w_q2)
  );

  assign w_rem_nxt  = w_rem2;
  assign w_quot_nxt = {r_quot[DATA_W-3:0], w_q1, w_q2};
  assign w_dvd_nxt  = {r_dvd[DATA_W-3:0], 2'b00};
`else
  assign w_rem_nxt  = w_rem1;
  assign w_quot_nxt = {r_quot[DATA_W-2:0], w_q1};
  assign w_dvd_nxt  = {r_dvd[DATA_W-2:0], 1'b0};
`endif

  // Signs are restored on the final step so END only has to publish r_res.
  assign w_quot_fin = r_neg_q ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
  assign w_rem_fin  = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_res    <= '0;
      r_result <= '0;
      r_ready  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state <= DIV_ON;
              r_cnt   <= '0;
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_quot  <= '0;
              r_neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg_r <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          r_res   <= '0;
          r_state <= DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_state <= DIV_FREE;
          end else begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_dvd  <= w_dvd_nxt;
            r_cnt  <= r_cnt + CNT_W'(STEPS);
            if (r_cnt == C_LAST) begin
              r_res   <= {w_rem_fin, w_quot_fin};
              r_state <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            r_state  <= DIV_FREE;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
          end else begin
            r_ready  <= DIV_RESULT_READY;
            r_result <= r_res;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// tb_ex_div : scoreboard bench for ex_div (radix-2 or EX_DIV_RADIX4_EN build)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ex_div;

`ifdef EX_DIV_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_res[$];
  int          sb_lat[$];

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 64-bit so the 0x80000000 / -1 case does not overflow.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb_res.push_back(exp);
    sb_lat.push_back((b == 32'h0) ? 3 : LAT);
  endtask

  task automatic collect(input string tag);
    int          edges;
    int          lat;
    logic [63:0] exp;
    bit          seen;
    edges = 0;
    seen  = 1'b0;
    exp   = sb_res.pop_front();
    lat   = sb_lat.pop_front();
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) seen = 1'b1;
    end
    chk({tag, "_lat"}, 64'(edges), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, {63'h0, ready_o}, 64'h1);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {result_o[62:0], ready_o}, 64'h0);
  endtask

  initial begin
    int ready_seen;
    logic [31:0] a, b;
    bit sgn;

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {result_o[62:0], ready_o}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    collect("divu_100_7");
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    collect("div_m7_2");
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    collect("div_ovf");
    issue(1'b0, 32'd5, 32'd0, 64'h0);
    collect("divu_by0");

    // Annul mid-divide: the flush drops start together with annul.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1; start_i = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) ready_seen++;
    end
    chk("annul_noready", 64'(ready_seen), 64'h0);
    issue(1'b0, 32'd8, 32'd2, 64'h00000000_00000004);
    collect("divu_8_2");

    // Reset at edge 20 of an in-flight divide.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset", {result_o[62:0], ready_o}, 64'h0);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) ready_seen++;
    end
    chk("midreset_idle", 64'(ready_seen), 64'h0);
    issue(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    collect("div_7_m2");

    for (int i = 0; i < 6; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = 32'($urandom_range(1, 5000));
      if (sgn && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
      issue(sgn, a, b, model(sgn, a, b));
      collect($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle integer divider on the consumer side of the ID/EX boundary.
- The EX stage issues DIV/DIVU operands (ex_reg1/ex_reg2) to this block, stalls the pipeline until ready_o, then writes HI/LO.
- Restoring division, one quotient bit per cycle, signed and unsigned.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W.
CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low (`RstEnable = 1'b0)
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
start_i  input  1  request; held high by EX until ready_o is seen
annul_i  input  1  abort in-flight divide (flush/exception)
result_o  output  2*DATA_W  {remainder (HI), quotient (LO)}
ready_o  output  1  result valid

Behaviour:
- Reset (rst==0 at posedge): state=FREE, ready_o=0, result_o=0, counter=0. Reset overrides every state, including mid-operation.
- All outputs are registered.
- FREE:
  - start_i=1 and annul_i=0, divisor==0 -> BYZERO.
  - start_i=1 and annul_i=0, divisor!=0 -> ON. Latch operands, converting to absolute values when signed_div_i=1 and the operand MSB is 1. Clear the counter.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: next edge -> END with an internal result of 0.
- ON:
  - annul_i=1 -> FREE on the next edge. No ready pulse, result discarded.
  - Otherwise, each edge performs one shift/trial-subtract step and increments the counter.
  - After the DATA_W-th step -> END. If signed and operand signs differ, negate the quotient. If signed and the dividend was negative, negate the remainder.
- END:
  - ready_o=1; result_o holds the final value.
  - Stays in END while start_i=1.
  - When start_i=0 -> FREE; ready_o returns to 0 and result_o to 0 on that edge.
- Latency: start sampled at edge 1, ready_o high after edge DATA_W+2 (34 for 32-bit). Divide-by-zero gives ready after edge 3.
- Signed 0x80000000 / -1: quotient wraps to 0x80000000, remainder 0; no trap.
- start_i while in ON/BYZERO is ignored (no restart). annul_i in FREE/END has no effect beyond FREE's gating.
- Width rules:
  - Partial remainder is DATA_W+1 bits; subtraction is unsigned.
  - Negation is two's complement modulo 2^DATA_W.

Optional Feature:
- Macro EX_DIV_RADIX4_EN.
- Defined: two quotient bits per cycle, so ON lasts DATA_W/2 edges and ready_o is high after edge DATA_W/2+2 (18).
- Undefined: radix-2 as above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package (precompiled.v), holding:
  - state encodings DivFree/DivByZero/DivOn/DivEnd
  - DivResultReady/DivResultNotReady and DivStart/DivStop
  - `RstEnable`, `ZeroWord`, `DoubleRegBus`
- One natural sub-module, ex_div_step: combinational single-bit trial-subtract returning the next partial remainder and quotient bit. Instantiated once, or twice chained under EX_DIV_RADIX4_EN.

Test Plan:
1. DIVU 100/7, start held -> ready_o rises after edge 34, result_o=64'h00000002_0000000E; drop start -> ready_o=0, result_o=0 next edge.
2. DIV 0xFFFFFFF9(-7)/2 -> result_o=64'hFFFFFFFF_FFFFFFFD. DIV 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000.
3. DIVU 5/0 -> ready_o after edge 3, result_o=0.
4. DIVU 0xFFFFFFFF/1; annul_i pulsed at edge 10 -> FREE, ready_o never rises. Then DIVU 8/2 -> 64'h00000000_00000004 after edge 34.
5. rst=0 for one cycle at edge 20 of a divide -> all outputs 0, state FREE. A subsequent DIV 0x00000007/0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
6. EX_DIV_RADIX4_EN build: repeat tests 1 and 2 -> identical results, ready after edge 18.
